// File: rtl/sensor_vaga_ultrassom_if.sv
// Sensor-side bundle for one parking spot front end.
// The DUT side uses master; a sensor/display model uses slave.
interface sensor_vaga_ultrassom_if #(
  parameter int ECHO_MAX_CYCLES = 600000
);
  localparam int W = $clog2(ECHO_MAX_CYCLES + 1);

  logic         echo_in;
  logic         trig_out;
  logic         vaga_out;
  logic         medida_valida;
  logic [W-1:0] largura_eco;
  logic         erro_timeout;

  modport master (
    input  echo_in,
    output trig_out,
    output vaga_out,
    output medida_valida,
    output largura_eco,
    output erro_timeout
  );

  modport slave (
    output echo_in,
    input  trig_out,
    input  vaga_out,
    input  medida_valida,
    input  largura_eco,
    input  erro_timeout
  );
endinterface

// File: rtl/sensor_vaga_ultrassom.sv
// Ultrasonic parking-spot sensor: trigger, echo width, hysteresis
// classification and N-in-a-row confirmation of the occupied flag.
module sensor_vaga_ultrassom #(
  parameter int TRIG_CYCLES     = 250,
  parameter int RISE_TIMEOUT    = 25000,
  parameter int ECHO_MAX_CYCLES = 600000,
  parameter int LIM_OCUP        = 15000,
  parameter int LIM_LIVRE       = 20000,
  parameter int GAP_CYCLES      = 1500000,
  parameter int CONFIRM_N       = 3
) (
  input  logic clk,
  input  logic rst,
  sensor_vaga_ultrassom_if.master bus
);
  localparam int W  = $clog2(ECHO_MAX_CYCLES + 1);
  localparam int M1 = (TRIG_CYCLES > RISE_TIMEOUT) ?
                      TRIG_CYCLES : RISE_TIMEOUT;
  localparam int M2 = (M1 > ECHO_MAX_CYCLES) ?
                      M1 : ECHO_MAX_CYCLES;
  localparam int M3 = (M2 > GAP_CYCLES) ? M2 : GAP_CYCLES;
  localparam int CW = $clog2(M3 + 1);
  localparam int NW = $clog2(CONFIRM_N + 1);

  localparam logic [CW-1:0] C_TRIG  = CW'(TRIG_CYCLES);
  localparam logic [CW-1:0] C_RISE  = CW'(RISE_TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX   = CW'(ECHO_MAX_CYCLES);
  localparam logic [CW-1:0] C_OCUP  = CW'(LIM_OCUP);
  localparam logic [CW-1:0] C_LIVRE = CW'(LIM_LIVRE);
  localparam logic [CW-1:0] C_GAP   = CW'(GAP_CYCLES - 1);
  localparam logic [NW-1:0] C_CONF  = NW'(CONFIRM_N);

  localparam logic [2:0] S_TRIG = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          echo_m;
  logic          echo_s;
  logic          trig_q;
  logic          vaga_q;
  logic          val_q;
  logic [W-1:0]  larg_q;
  logic          erro_q;
  logic          cand;
  logic [NW-1:0] conf;
  logic          cand_n;
  logic          sat;
  logic [NW-1:0] conf_inc;
  logic          conf_hit;

  assign bus.trig_out      = trig_q;
  assign bus.vaga_out      = vaga_q;
  assign bus.medida_valida = val_q;
  assign bus.largura_eco   = larg_q;
  assign bus.erro_timeout  = erro_q;

  // Two-flop synchronizer for the asynchronous echo line
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      echo_m <= bus.echo_in;
      echo_s <= echo_m;
    end
  end

  // Classify the finished width; the band keeps the old candidate
  always_comb begin
    sat      = (cnt >= C_MAX);
    cand_n   = cand;
    conf_inc = conf + NW'(1);
    conf_hit = (conf_inc >= C_CONF);
    unique case (1'b1)
      sat:                      cand_n = 1'b0;
      !sat && (cnt < C_OCUP):   cand_n = 1'b1;
      !sat && (cnt > C_LIVRE):  cand_n = 1'b0;
      default:                  cand_n = cand;
    endcase
  end

  // Measurement loop: trigger, wait edge, measure, publish, idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_TRIG;
      cnt    <= '0;
      armed  <= 1'b0;
      trig_q <= 1'b0;
      vaga_q <= 1'b0;
      val_q  <= 1'b0;
      larg_q <= '0;
      erro_q <= 1'b0;
      cand   <= 1'b0;
      conf   <= '0;
    end else begin
      val_q <= 1'b0;
      unique case (state)
        S_TRIG: begin
          if (cnt >= C_TRIG) begin
            trig_q <= 1'b0;
            cnt    <= '0;
            armed  <= 1'b0;
            state  <= S_WAIT;
          end else begin
            trig_q <= 1'b1;
            cnt    <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (armed && echo_s) begin
            cnt   <= CW'(1);
            state <= S_MEAS;
          end else if (cnt >= C_RISE) begin
            erro_q <= 1'b1;
            cnt    <= '0;
            state  <= S_GAP;
          end else begin
            cnt   <= cnt + CW'(1);
            armed <= armed | ~echo_s;
          end
        end
        S_MEAS: begin
          if (!echo_s || sat) begin
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EVAL: begin
          larg_q <= cnt[W-1:0];
          val_q  <= 1'b1;
          erro_q <= 1'b0;
          cand   <= cand_n;
          if (cand_n == vaga_q) begin
            conf <= '0;
          end else if (conf_hit) begin
            vaga_q <= cand_n;
            conf   <= '0;
          end else begin
            conf <= conf_inc;
          end
          cnt   <= '0;
          state <= S_GAP;
        end
        S_GAP: begin
          if (cnt >= C_GAP) begin
            trig_q <= 1'b1;
            cnt    <= CW'(1);
            state  <= S_TRIG;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_TRIG;
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_vaga_ultrassom.sv
// Bench for sensor_vaga_ultrassom: directed echo widths,
// expected results queued by the driver, checked by a monitor.
module tb_sensor_vaga_ultrassom;
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sensor_vaga_ultrassom_if #(.ECHO_MAX_CYCLES(100)) bus ();

  sensor_vaga_ultrassom #(
    .TRIG_CYCLES(4),
    .RISE_TIMEOUT(20),
    .ECHO_MAX_CYCLES(100),
    .LIM_OCUP(30),
    .LIM_LIVRE(40),
    .GAP_CYCLES(10),
    .CONFIRM_N(3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit tmo;
    int larg;
    bit vaga;
  } exp_t;

  exp_t q[$];
  int checks;
  int failures;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_trig"}, int'(bus.trig_out), 0);
    chk({tag, "_vaga"}, int'(bus.vaga_out), 0);
    chk({tag, "_valida"}, int'(bus.medida_valida), 0);
    chk({tag, "_largura"}, int'(bus.largura_eco), 0);
    chk({tag, "_erro"}, int'(bus.erro_timeout), 0);
  endtask

  task automatic trig_pulse_check(string tag);
    int n;
    int first;
    n = 0;
    first = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 0) first = int'(bus.trig_out);
      if (bus.trig_out) n++;
      else break;
    end
    chk({tag, "_trig_first"}, first, 1);
    chk({tag, "_trig_width"}, n, 4);
  endtask

  task automatic wait_trig_fall();
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.trig_out) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL trig_fall_wait actual=none required=fall");
    end
  endtask

  task automatic do_echo(int n);
    repeat (3) @(negedge clk);
    bus.echo_in = 1'b1;
    repeat (n) @(negedge clk);
    bus.echo_in = 1'b0;
  endtask

  task automatic meas(int n, int larg, bit v, bit first);
    exp_t e;
    if (!first) wait_trig_fall();
    e = '{tmo: 1'b0, larg: larg, vaga: v};
    q.push_back(e);
    do_echo(n);
  endtask

  task automatic push_tmo(bit v);
    exp_t e;
    e = '{tmo: 1'b1, larg: 0, vaga: v};
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per published result
  initial begin
    exp_t e;
    bit prev_trig;
    prev_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.medida_valida) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_medida actual=%0d required=none",
                     bus.largura_eco);
          end else begin
            e = q.pop_front();
            chk("meas_kind", 0, int'(e.tmo));
            chk("meas_largura", int'(bus.largura_eco), e.larg);
            chk("meas_vaga", int'(bus.vaga_out), int'(e.vaga));
            chk("meas_erro", int'(bus.erro_timeout), 0);
          end
        end
        if (bus.trig_out && !prev_trig &&
            q.size() > 0 && q[0].tmo) begin
          e = q.pop_front();
          chk("tmo_erro", int'(bus.erro_timeout), 1);
          chk("tmo_vaga", int'(bus.vaga_out), int'(e.vaga));
        end
      end
      prev_trig = bus.trig_out;
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.echo_in = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("rst1");
    rst = 1'b0;
    trig_pulse_check("start");

    meas(10, 10, 1'b0, 1'b1);
    meas(10, 10, 1'b0, 1'b0);
    meas(10, 10, 1'b1, 1'b0);

    meas(35, 35, 1'b1, 1'b0);
    meas(35, 35, 1'b1, 1'b0);
    meas(35, 35, 1'b1, 1'b0);
    meas(50, 50, 1'b1, 1'b0);
    meas(50, 50, 1'b1, 1'b0);
    meas(50, 50, 1'b0, 1'b0);

    meas(10, 10, 1'b0, 1'b0);
    meas(10, 10, 1'b0, 1'b0);
    meas(10, 10, 1'b1, 1'b0);
    meas(50, 50, 1'b1, 1'b0);
    meas(10, 10, 1'b1, 1'b0);
    meas(50, 50, 1'b1, 1'b0);
    meas(50, 50, 1'b1, 1'b0);
    meas(50, 50, 1'b0, 1'b0);

    wait_trig_fall();
    push_tmo(1'b0);
    repeat (25) @(negedge clk);
    bus.echo_in = 1'b1;
    wait_trig_fall();
    push_tmo(1'b0);
    repeat (25) @(negedge clk);
    bus.echo_in = 1'b0;
    meas(10, 10, 1'b0, 1'b0);

    meas(105, 100, 1'b0, 1'b0);

    wait_trig_fall();
    repeat (3) @(negedge clk);
    bus.echo_in = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.echo_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst2");
    rst = 1'b0;
    trig_pulse_check("restart");
    meas(50, 50, 1'b0, 1'b1);

    repeat (30) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
